// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer using radix-2 restoring division.
// Define DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow at accept.
module div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_E,
  input  logic [1:0]      op_E,
  input  logic [XLEN-1:0] rs1_E_val,
  input  logic [XLEN-1:0] rs2_E_val,
  input  logic [4:0]      rd_E,
  input  logic            kill,
  output logic            div_stalled,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_quo_q, neg_rem_q, div0_q, ovf_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            accept;
  logic            is_signed, s1, s2, div0_d, ovf_d;
  logic [XLEN-1:0] abs1_d, abs2_d;
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_d, quo_d, quo_fix, rem_fix, fin_d;

  assign accept      = start_E & ~kill & (state_q != BUSY);
  assign div_stalled = (state_q == BUSY) | accept;
  assign done        = done_q;
  assign result      = result_q;
  assign rd_out      = rd_out_q;

  always_comb begin
    is_signed = ~op_E[0];
    s1        = is_signed & rs1_E_val[XLEN-1];
    s2        = is_signed & rs2_E_val[XLEN-1];
    abs1_d    = s1 ? -rs1_E_val : rs1_E_val;
    abs2_d    = s2 ? -rs2_E_val : rs2_E_val;
    div0_d    = (rs2_E_val == '0);
    ovf_d     = is_signed & (rs1_E_val == SMIN) & (rs2_E_val == '1);
  end

  // rem_sh is one bit wider: with a divisor above 2^(XLEN-1) the shifted
  // partial remainder can exceed XLEN bits before the trial subtract.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_d   = fits ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], fits};
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
    if (div0_q) begin
      quo_fix = '1;
      rem_fix = dvd_q;
    end else if (ovf_q) begin
      quo_fix = dvd_q;
      rem_fix = '0;
    end
    fin_d = op_q[1] ? rem_fix : quo_fix;
  end

`ifdef DIV_FASTPATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  assign fast_hit = div0_d | ovf_d;
  assign fast_res = div0_d ? (op_E[1] ? rs1_E_val : '1) : (op_E[1] ? '0 : rs1_E_val);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
      end else if (accept) begin
        op_q      <= op_E;
        rd_q      <= rd_E;
        neg_quo_q <= s1 ^ s2;
        neg_rem_q <= s1;
        div0_q    <= div0_d;
        ovf_q     <= ovf_d;
        dvd_q     <= rs1_E_val;
        dvs_q     <= abs2_d;
        quo_q     <= abs1_d;
        rem_q     <= '0;
        cnt_q     <= CNT_LOAD;
`ifdef DIV_FASTPATH_EN
        if (fast_hit) begin
          state_q  <= DONE;
          done_q   <= 1'b1;
          result_q <= fast_res;
          rd_out_q <= rd_E;
        end else begin
          state_q <= BUSY;
        end
`else
        state_q <= BUSY;
`endif
      end else begin
        case (state_q)
          BUSY: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= fin_d;
              rd_out_q <= rd_q;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed and randomized ops against an arithmetic model.
module tb_div_sequencer;
  localparam int unsigned XLEN = 32;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst, start_E, kill;
  logic [1:0]  op_E;
  logic [31:0] rs1_E_val, rs2_E_val, result;
  logic [4:0]  rd_E, rd_out;
  logic        div_stalled, done;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bit          nxt_valid = 1'b0;
  logic [1:0]  nxt_op;
  logic [31:0] nxt_a, nxt_b;
  logic [4:0]  nxt_rd;

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_E    (start_E),
    .op_E       (op_E),
    .rs1_E_val  (rs1_E_val),
    .rs2_E_val  (rs2_E_val),
    .rd_E       (rd_E),
    .kill       (kill),
    .div_stalled(div_stalled),
    .done       (done),
    .result     (result),
    .rd_out     (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    bit  ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (FAST && special) ? 1 : XLEN + 1;
  endfunction

  // Entry: posedge+1 (or, when chained, the negedge of the previous DONE cycle with inputs driven).
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit chained, input logic [31:0] exp_res);
    int unsigned lat;
    int unsigned got_cyc;
    bit          stall_ok;
    bit          got;
    logic [31:0] res_at;
    logic [4:0]  rd_at;
    lat      = ref_lat(op, a, b);
    got_cyc  = 0;
    stall_ok = 1'b1;
    got      = 1'b0;
    res_at   = 'x;
    rd_at    = 'x;
    if (!chained) begin
      start_E = 1'b1; op_E = op; rs1_E_val = a; rs2_E_val = b; rd_E = rd;
      @(negedge clk);
    end else begin
      n_total++;
      if (done !== 1'b1) $display("FAIL %s chained_done_held: got %b expected 1", nm, done);
      else n_pass++;
    end
    #1;
    if (div_stalled !== 1'b1) stall_ok = 1'b0;
    @(posedge clk); #1;
    start_E = 1'b0;
    for (int unsigned c = 1; c <= XLEN + 8 && !got; c++) begin
      @(negedge clk);
      if (div_stalled !== (c < lat)) stall_ok = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1; got_cyc = c; res_at = result; rd_at = rd_out;
      end else begin
        @(posedge clk); #1;
      end
    end
    n_total++;
    if (got_cyc != lat) $display("FAIL %s latency: got %0d expected %0d", nm, got_cyc, lat);
    else n_pass++;
    n_total++;
    if (res_at !== exp_res) $display("FAIL %s result: got %h expected %h", nm, res_at, exp_res);
    else n_pass++;
    n_total++;
    if (rd_at !== rd) $display("FAIL %s rd_out: got %0d expected %0d", nm, rd_at, rd);
    else n_pass++;
    n_total++;
    if (!stall_ok) $display("FAIL %s stall_window: got bad div_stalled pattern expected high for cycles 0..%0d", nm, lat - 1);
    else n_pass++;
    if (got && nxt_valid) begin
      start_E = 1'b1; op_E = nxt_op; rs1_E_val = nxt_a; rs2_E_val = nxt_b; rd_E = nxt_rd;
      nxt_valid = 1'b0;
    end else begin
      nxt_valid = 1'b0;
      if (got) begin
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || div_stalled !== 1'b0)
          $display("FAIL %s after_done: got done=%b stall=%b expected 0/0", nm, done, div_stalled);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_E = 1'b0; kill = 1'b0; op_E = '0; rs1_E_val = '0; rs2_E_val = '0; rd_E = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || div_stalled !== 1'b0)
      $display("FAIL reset_ctrl: got done=%b stall=%b expected 0/0", done, div_stalled);
    else n_pass++;
    n_total++;
    if (result !== 32'h0 || rd_out !== 5'd0)
      $display("FAIL reset_data: got result=%h rd_out=%0d expected 0/0", result, rd_out);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op("divu_100_7",  2'b01, 32'd100,        32'd7,          5'd1,  1'b0, 32'd14);
    do_op("remu_100_7",  2'b11, 32'd100,        32'd7,          5'd2,  1'b0, 32'd2);
    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          5'd3,  1'b0, 32'hFFFF_FFFD);
    do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          5'd4,  1'b0, 32'hFFFF_FFFF);
    do_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  5'd5,  1'b0, 32'hFFFF_FFFD);
    do_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  5'd6,  1'b0, 32'd1);
    do_op("div_5_0",     2'b00, 32'd5,          32'd0,          5'd7,  1'b0, 32'hFFFF_FFFF);
    do_op("rem_5_0",     2'b10, 32'd5,          32'd0,          5'd8,  1'b0, 32'd5);
    do_op("rem_m7_0",    2'b10, 32'hFFFF_FFF9,  32'd0,          5'd9,  1'b0, 32'hFFFF_FFF9);
    do_op("divu_5_0",    2'b01, 32'd5,          32'd0,          5'd10, 1'b0, 32'hFFFF_FFFF);
    do_op("remu_5_0",    2'b11, 32'd5,          32'd0,          5'd11, 1'b0, 32'd5);
    do_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 1'b0, 32'h8000_0000);
    do_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 1'b0, 32'h0);
    do_op("divu_big",    2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  5'd14, 1'b0, 32'd1);
    do_op("remu_big",    2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  5'd15, 1'b0, 32'h7FFF_FFFF);
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int unsigned sel;
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'h0;
      else if (sel == 1) b = 32'hFFFF_FFFF;
      else if (sel < 5)  b = $urandom_range(1, 50);
      else               b = $urandom();
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
      rd = 5'($urandom_range(0, 31));
      do_op("random", op, a, b, rd, 1'b0, ref_div(op, a, b));
    end
  endtask

  task automatic test_kill();
    bit seen;
    do_op("kill_pre", 2'b01, 32'd1000, 32'd10, 5'd3, 1'b0, 32'd100);
    start_E = 1'b1; op_E = 2'b01; rs1_E_val = 32'd100; rs2_E_val = 32'd7; rd_E = 5'd9;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(negedge clk);
    n_total++;
    if (div_stalled !== 1'b1) $display("FAIL kill_c10_stall: got %b expected 1", div_stalled);
    else n_pass++;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    n_total++;
    if (div_stalled !== 1'b0 || done !== 1'b0)
      $display("FAIL kill_c11_idle: got stall=%b done=%b expected 0/0", div_stalled, done);
    else n_pass++;
    n_total++;
    if (result !== 32'd100) $display("FAIL kill_result_held: got %h expected %h", result, 32'd100);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL kill_no_done: got done pulse expected none");
    else n_pass++;
    @(posedge clk); #1;
    start_E = 1'b1; kill = 1'b1; op_E = 2'b01; rs1_E_val = 32'd50; rs2_E_val = 32'd5; rd_E = 5'd1;
    #1;
    n_total++;
    if (div_stalled !== 1'b0) $display("FAIL kill_prio_stall: got %b expected 0", div_stalled);
    else n_pass++;
    @(posedge clk); #1;
    start_E = 1'b0; kill = 1'b0;
    @(negedge clk);
    n_total++;
    if (div_stalled !== 1'b0) $display("FAIL kill_prio_idle: got %b expected 0", div_stalled);
    else n_pass++;
    @(posedge clk); #1;
    do_op("post_kill", 2'b01, 32'd9, 32'd3, 5'd7, 1'b0, 32'd3);
  endtask

  task automatic test_back_to_back();
    nxt_valid = 1'b1; nxt_op = 2'b01; nxt_a = 32'd9; nxt_b = 32'd3; nxt_rd = 5'd6;
    do_op("b2b_first",  2'b01, 32'd100, 32'd7, 5'd5, 1'b0, 32'd14);
    do_op("b2b_second", 2'b01, 32'd9,   32'd3, 5'd6, 1'b1, 32'd3);
  endtask

  task automatic test_reset_mid();
    start_E = 1'b1; op_E = 2'b01; rs1_E_val = 32'd100; rs2_E_val = 32'd7; rd_E = 5'd4;
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_total++;
    if (done !== 1'b0 || div_stalled !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0)
      $display("FAIL reset_mid: got done=%b stall=%b result=%h rd=%0d expected all 0",
               done, div_stalled, result, rd_out);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("post_reset", 2'b01, 32'd8, 32'd2, 5'd2, 1'b0, 32'd4);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
